// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/memory/write-back
// control for the 16-bit datapath over one shared memory port.
module cpu_sequencer #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_mem_rddata,
    input  logic        i_mem_waitreq,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic        i_reg_write,
    input  logic        i_nz_update,
    input  logic        i_halt,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic        o_mem_sel,
    output logic [15:0] o_ir,
    output logic        o_ir_valid,
    output logic [15:0] o_ld_data,
    output logic        o_pc_en,
    output logic        o_reg_we,
    output logic        o_nz_we,
    output logic [15:0] o_icount,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        FWAIT  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        MWAIT  = 3'd5,
        WB     = 3'd6,
        HALT   = 3'd7
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    state_t      state;
    state_t      state_nx;
    logic [2:0]  wait_cnt;
    logic        is_ld;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_sel;
    logic        pc_en;
    logic        reg_we;
    logic        nz_we;
    logic        retire;
    logic        load_cnt;
    logic        cap_ir;
    logic        cap_ld;
    logic        latch_cls;

    // State register, wait counter, instruction/load latches, retire count
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            wait_cnt <= 3'd0;
            is_ld    <= 1'b0;
            o_ir     <= 16'h0000;
            o_ld_data <= 16'h0000;
            o_icount <= 16'h0000;
        end else begin
            state <= state_nx;
            if (load_cnt) begin
                wait_cnt <= LAT_INIT;
            end else if (wait_cnt != 3'd0) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            if (latch_cls) begin
                is_ld <= i_is_load;
            end
            if (cap_ir) begin
                o_ir <= i_mem_rddata;
            end
            if (cap_ld) begin
                o_ld_data <= i_mem_rddata;
            end
            if (retire) begin
                o_icount <= o_icount + 16'd1;
            end
        end
    end

    // Next-state and strobe decode from the registered state
    always_comb begin
        state_nx  = state;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_sel   = 1'b0;
        pc_en     = 1'b0;
        reg_we    = 1'b0;
        nz_we     = 1'b0;
        retire    = 1'b0;
        load_cnt  = 1'b0;
        cap_ir    = 1'b0;
        cap_ld    = 1'b0;
        latch_cls = 1'b0;
        unique case (state)
            FETCH: begin
                if (i_halt) begin
                    state_nx = HALT;
                end else begin
                    mem_rd = 1'b1;
                    if (!i_mem_waitreq) begin
                        state_nx = FWAIT;
                        load_cnt = 1'b1;
                    end
                end
            end
            FWAIT: begin
                if (wait_cnt == 3'd0) begin
                    cap_ir   = 1'b1;
                    state_nx = DECODE;
                end
            end
            DECODE: begin
                latch_cls = 1'b1;
                if (i_is_load || i_is_store) begin
                    state_nx = MEM;
                end else begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                pc_en    = 1'b1;
                reg_we   = i_reg_write;
                nz_we    = i_nz_update;
                retire   = 1'b1;
                state_nx = FETCH;
            end
            MEM: begin
                mem_sel = 1'b1;
                if (is_ld) begin
                    mem_rd = 1'b1;
                    if (!i_mem_waitreq) begin
                        state_nx = MWAIT;
                        load_cnt = 1'b1;
                    end
                end else begin
                    mem_wr = 1'b1;
                    if (!i_mem_waitreq) begin
                        pc_en    = 1'b1;
                        retire   = 1'b1;
                        state_nx = FETCH;
                    end
                end
            end
            MWAIT: begin
                if (wait_cnt == 3'd0) begin
                    cap_ld   = 1'b1;
                    state_nx = WB;
                end
            end
            WB: begin
                reg_we   = 1'b1;
                nz_we    = i_nz_update;
                pc_en    = 1'b1;
                retire   = 1'b1;
                state_nx = FETCH;
            end
            HALT: begin
                if (!i_halt) begin
                    state_nx = FETCH;
                end
            end
            default: begin
                state_nx = FETCH;
            end
        endcase
    end

    // Strobes are held low for as long as reset is asserted
    assign o_mem_rd   = mem_rd & ~reset;
    assign o_mem_wr   = mem_wr & ~reset;
    assign o_mem_sel  = mem_sel & ~reset;
    assign o_pc_en    = pc_en & ~reset;
    assign o_reg_we   = reg_we & ~reset;
    assign o_nz_we    = nz_we & ~reset;
    assign o_ir_valid = (state inside {DECODE, EXEC, MEM, MWAIT, WB});
    assign o_state    = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed vector table, randomized run against an
// instruction-level memory/timing model, and icount wrap-around.
module tb_cpu_sequencer;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] i_mem_rddata = 16'h0000;
    logic        i_mem_waitreq = 1'b0;
    logic        i_is_load = 1'b0;
    logic        i_is_store = 1'b0;
    logic        i_reg_write = 1'b0;
    logic        i_nz_update = 1'b0;
    logic        i_halt = 1'b0;
    logic        o_mem_rd;
    logic        o_mem_wr;
    logic        o_mem_sel;
    logic [15:0] o_ir;
    logic        o_ir_valid;
    logic [15:0] o_ld_data;
    logic        o_pc_en;
    logic        o_reg_we;
    logic        o_nz_we;
    logic [15:0] o_icount;
    logic [2:0]  o_state;

    int total = 0;
    int bad = 0;

    cpu_sequencer #(.MEM_LAT(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_mem_rddata (i_mem_rddata),
        .i_mem_waitreq(i_mem_waitreq),
        .i_is_load    (i_is_load),
        .i_is_store   (i_is_store),
        .i_reg_write  (i_reg_write),
        .i_nz_update  (i_nz_update),
        .i_halt       (i_halt),
        .o_mem_rd     (o_mem_rd),
        .o_mem_wr     (o_mem_wr),
        .o_mem_sel    (o_mem_sel),
        .o_ir         (o_ir),
        .o_ir_valid   (o_ir_valid),
        .o_ld_data    (o_ld_data),
        .o_pc_en      (o_pc_en),
        .o_reg_we     (o_reg_we),
        .o_nz_we      (o_nz_we),
        .o_icount     (o_icount),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got=timeout want=event", name);
    endtask

    // in = {rst, waitreq, halt, is_load, is_store, reg_write, nz_update}
    // estb = {mem_rd, mem_wr, mem_sel, pc_en, reg_we, nz_we, ir_valid}
    typedef struct {
        logic [6:0]  in;
        logic [15:0] rd;
        logic [2:0]  est;
        logic [6:0]  estb;
        logic [15:0] eir;
        logic [15:0] eld;
        logic [15:0] eic;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [6:0] in, input logic [15:0] rd,
                       input logic [2:0] est, input logic [6:0] estb,
                       input logic [15:0] eir, input logic [15:0] eld,
                       input logic [15:0] eic);
        vec_t v;
        v.in = in;
        v.rd = rd;
        v.est = est;
        v.estb = estb;
        v.eir = eir;
        v.eld = eld;
        v.eic = eic;
        tbl.push_back(v);
    endtask

    task automatic fill_table();
        // reset held: FETCH strobes gated
        add(7'b1000000, 16'h0000, 3'd0, 7'b0000000, 16'h0, 16'h0, 16'd0);
        // ALU op
        add(7'b0000000, 16'h0000, 3'd0, 7'b1000000, 16'h0, 16'h0, 16'd0);
        add(7'b0000000, 16'h0000, 3'd1, 7'b0000000, 16'h0, 16'h0, 16'd0);
        add(7'b0000000, 16'h0000, 3'd1, 7'b0000000, 16'h0, 16'h0, 16'd0);
        add(7'b0000000, 16'h1234, 3'd1, 7'b0000000, 16'h0, 16'h0, 16'd0);
        add(7'b0000011, 16'h0000, 3'd2, 7'b0000001, 16'h1234, 16'h0, 16'd0);
        add(7'b0000011, 16'h0000, 3'd3, 7'b0001111, 16'h1234, 16'h0, 16'd0);
        // fetch stall 4 cycles, then store with 2 stall cycles
        add(7'b0100000, 16'h0000, 3'd0, 7'b1000000, 16'h1234, 16'h0, 16'd1);
        add(7'b0100000, 16'h0000, 3'd0, 7'b1000000, 16'h1234, 16'h0, 16'd1);
        add(7'b0100000, 16'h0000, 3'd0, 7'b1000000, 16'h1234, 16'h0, 16'd1);
        add(7'b0100000, 16'h0000, 3'd0, 7'b1000000, 16'h1234, 16'h0, 16'd1);
        add(7'b0000000, 16'h0000, 3'd0, 7'b1000000, 16'h1234, 16'h0, 16'd1);
        add(7'b0000000, 16'h0000, 3'd1, 7'b0000000, 16'h1234, 16'h0, 16'd1);
        add(7'b0000000, 16'h0000, 3'd1, 7'b0000000, 16'h1234, 16'h0, 16'd1);
        add(7'b0000000, 16'hC0DE, 3'd1, 7'b0000000, 16'h1234, 16'h0, 16'd1);
        add(7'b0000100, 16'h0000, 3'd2, 7'b0000001, 16'hC0DE, 16'h0, 16'd1);
        add(7'b0100000, 16'h0000, 3'd4, 7'b0110001, 16'hC0DE, 16'h0, 16'd1);
        add(7'b0100000, 16'h0000, 3'd4, 7'b0110001, 16'hC0DE, 16'h0, 16'd1);
        add(7'b0000000, 16'h0000, 3'd4, 7'b0111001, 16'hC0DE, 16'h0, 16'd1);
        // load, load+store both decoded, class latched at DECODE
        add(7'b0000000, 16'h0000, 3'd0, 7'b1000000, 16'hC0DE, 16'h0, 16'd2);
        add(7'b0000000, 16'h0000, 3'd1, 7'b0000000, 16'hC0DE, 16'h0, 16'd2);
        add(7'b0000000, 16'h0000, 3'd1, 7'b0000000, 16'hC0DE, 16'h0, 16'd2);
        add(7'b0000000, 16'h8001, 3'd1, 7'b0000000, 16'hC0DE, 16'h0, 16'd2);
        add(7'b0001100, 16'h0000, 3'd2, 7'b0000001, 16'h8001, 16'h0, 16'd2);
        add(7'b0000100, 16'h0000, 3'd4, 7'b1010001, 16'h8001, 16'h0, 16'd2);
        add(7'b0000000, 16'h0000, 3'd5, 7'b0000001, 16'h8001, 16'h0, 16'd2);
        add(7'b0000000, 16'h0000, 3'd5, 7'b0000001, 16'h8001, 16'h0, 16'd2);
        add(7'b0000000, 16'hBEEF, 3'd5, 7'b0000001, 16'h8001, 16'h0, 16'd2);
        add(7'b0000000, 16'h0000, 3'd6, 7'b0001101, 16'h8001, 16'hBEEF, 16'd2);
        // ALU op with halt raised in DECODE/EXEC, then HALT and exit
        add(7'b0000000, 16'h0000, 3'd0, 7'b1000000, 16'h8001, 16'hBEEF, 16'd3);
        add(7'b0000000, 16'h0000, 3'd1, 7'b0000000, 16'h8001, 16'hBEEF, 16'd3);
        add(7'b0000000, 16'h0000, 3'd1, 7'b0000000, 16'h8001, 16'hBEEF, 16'd3);
        add(7'b0000000, 16'h4242, 3'd1, 7'b0000000, 16'h8001, 16'hBEEF, 16'd3);
        add(7'b0010000, 16'h0000, 3'd2, 7'b0000001, 16'h4242, 16'hBEEF, 16'd3);
        add(7'b0010001, 16'h0000, 3'd3, 7'b0001011, 16'h4242, 16'hBEEF, 16'd3);
        add(7'b0010000, 16'h0000, 3'd0, 7'b0000000, 16'h4242, 16'hBEEF, 16'd4);
        add(7'b0010000, 16'h0000, 3'd7, 7'b0000000, 16'h4242, 16'hBEEF, 16'd4);
        add(7'b0000000, 16'h0000, 3'd7, 7'b0000000, 16'h4242, 16'hBEEF, 16'd4);
        // load interrupted by reset in MWAIT; late data ignored
        add(7'b0000000, 16'h0000, 3'd0, 7'b1000000, 16'h4242, 16'hBEEF, 16'd4);
        add(7'b0000000, 16'h0000, 3'd1, 7'b0000000, 16'h4242, 16'hBEEF, 16'd4);
        add(7'b0000000, 16'h0000, 3'd1, 7'b0000000, 16'h4242, 16'hBEEF, 16'd4);
        add(7'b0000000, 16'h9999, 3'd1, 7'b0000000, 16'h4242, 16'hBEEF, 16'd4);
        add(7'b0001000, 16'h0000, 3'd2, 7'b0000001, 16'h9999, 16'hBEEF, 16'd4);
        add(7'b0000000, 16'h0000, 3'd4, 7'b1010001, 16'h9999, 16'hBEEF, 16'd4);
        add(7'b1000000, 16'h0000, 3'd5, 7'b0000001, 16'h9999, 16'hBEEF, 16'd4);
        add(7'b0100000, 16'h5555, 3'd0, 7'b1000000, 16'h0, 16'h0, 16'd0);
        add(7'b0100000, 16'h5555, 3'd0, 7'b1000000, 16'h0, 16'h0, 16'd0);
        add(7'b0100000, 16'h0000, 3'd0, 7'b1000000, 16'h0, 16'h0, 16'd0);
    endtask

    task automatic run_table();
        logic [6:0] stb;
        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            {reset, i_mem_waitreq, i_halt, i_is_load,
             i_is_store, i_reg_write, i_nz_update} = tbl[i].in;
            i_mem_rddata = tbl[i].rd;
            #1;
            stb = {o_mem_rd, o_mem_wr, o_mem_sel, o_pc_en,
                   o_reg_we, o_nz_we, o_ir_valid};
            chk($sformatf("vec%0d_state", i), 32'(o_state),
                32'(tbl[i].est));
            chk($sformatf("vec%0d_strobes", i), 32'(stb),
                32'(tbl[i].estb));
            chk($sformatf("vec%0d_ir", i), 32'(o_ir), 32'(tbl[i].eir));
            chk($sformatf("vec%0d_ld", i), 32'(o_ld_data),
                32'(tbl[i].eld));
            chk($sformatf("vec%0d_icount", i), 32'(o_icount),
                32'(tbl[i].eic));
        end
    endtask

    // Memory returns data LAT cycles after an accepted read; each
    // instruction's length follows from its class and the stall cycles.
    task automatic run_random(input int ncyc);
        int          due_q[$];
        logic        kind_q[$];
        logic [15:0] exp_ir = 16'h0000;
        logic [15:0] exp_ld = 16'h0000;
        logic [15:0] w;
        logic [15:0] icm = 16'h0000;
        logic        busy = 1'b0;
        logic        irv_m = 1'b0;
        logic        irv_pend = 1'b0;
        logic        ld_c;
        logic        st_c;
        int          start = 0;
        int          stalls = 0;
        int          last_ret = 0;
        int          want;
        @(posedge clk);
        #1;
        reset = 1'b1;
        i_halt = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (irv_pend) begin
                irv_m = 1'b1;
                irv_pend = 1'b0;
            end
            i_mem_waitreq = ($urandom_range(0, 3) == 0);
            i_is_load = (o_ir[15:14] == 2'b10);
            i_is_store = o_ir[15] & (o_ir[14] | o_ir[2]);
            i_reg_write = o_ir[0];
            i_nz_update = o_ir[1];
            i_mem_rddata = 16'($urandom);
            if (due_q.size() > 0 && due_q[0] == c) begin
                w = 16'($urandom);
                i_mem_rddata = w;
                if (kind_q[0]) begin
                    exp_ld = w;
                end else begin
                    exp_ir = w;
                    irv_pend = 1'b1;
                end
                void'(due_q.pop_front());
                void'(kind_q.pop_front());
            end
            #1;
            ld_c = (exp_ir[15:14] == 2'b10);
            st_c = (exp_ir[15:14] == 2'b11);
            if (!busy && o_mem_rd && !o_mem_sel) begin
                busy = 1'b1;
                start = c;
                stalls = 0;
            end
            if ((o_mem_rd || o_mem_wr) && i_mem_waitreq) begin
                stalls++;
            end
            if (o_mem_rd && !i_mem_waitreq) begin
                due_q.push_back(c + LAT);
                kind_q.push_back(o_mem_sel);
            end
            chk("rnd_ir_valid", 32'(o_ir_valid), 32'(irv_m));
            chk("rnd_mem_class",
                32'((o_mem_wr && !(irv_m && st_c)) ||
                    (o_mem_rd && o_mem_sel && !(irv_m && ld_c))),
                32'(0));
            if (o_pc_en) begin
                chk("rnd_retire_busy", 32'(busy), 32'(1));
                want = stalls + LAT + 2 + (ld_c ? LAT + 2 : 1);
                chk("rnd_cycles", 32'(c - start + 1), 32'(want));
                chk("rnd_icount", 32'(o_icount), 32'(icm));
                chk("rnd_ir", 32'(o_ir), 32'(exp_ir));
                chk("rnd_reg_we", 32'(o_reg_we),
                    32'(ld_c ? 1'b1 : (st_c ? 1'b0 : exp_ir[0])));
                chk("rnd_nz_we", 32'(o_nz_we),
                    32'(st_c ? 1'b0 : exp_ir[1]));
                if (ld_c) begin
                    chk("rnd_ld_data", 32'(o_ld_data), 32'(exp_ld));
                end
                icm = icm + 16'd1;
                busy = 1'b0;
                irv_m = 1'b0;
                last_ret = c;
            end
            if (busy && (c - start) > 100) begin
                timeout("rnd_retire_wait");
                break;
            end
            if (!busy && (c - last_ret) > 20) begin
                timeout("rnd_fetch_wait");
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("rnd_icount_end", 32'(o_icount), 32'(icm));
    endtask

    task automatic wait_retire(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (o_pc_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_wrap();
        logic ok = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        i_mem_waitreq = 1'b0;
        i_halt = 1'b0;
        i_is_load = 1'b0;
        i_is_store = 1'b0;
        i_reg_write = 1'b0;
        i_nz_update = 1'b0;
        i_mem_rddata = 16'h0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 65535; k++) begin
            wait_retire(ok);
            if (!ok) break;
        end
        if (!ok) begin
            timeout("wrap_retire");
        end else begin
            @(posedge clk);
            #1;
            chk("wrap_ffff", 32'(o_icount), 32'(16'hFFFF));
            wait_retire(ok);
            if (!ok) begin
                timeout("wrap_last_retire");
            end else begin
                @(posedge clk);
                #1;
                chk("wrap_zero", 32'(o_icount), 32'(16'h0000));
            end
        end
    endtask

    initial begin
        fill_table();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        run_table();
        run_random(4000);
        run_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
